// File: rtl/ftdi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_cmd_sequencer
// Description : Parses 1..3 byte host commands from the FTDI byte stream.
//               It executes WRITE / READ / STATUS / CLEAR on an internal
//               8-bit register bank and returns exactly one response byte
//               per command over a valid/ack handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   in_clk         system clock
//   in_reset_n     asynchronous active-low reset
//   in_rx_data     received byte, qualified by in_rx_valid
//   in_rx_valid    one-cycle pulse per received byte
//   out_tx_data    response byte, stable while out_tx_valid is high
//   out_tx_valid   response pending, held until in_tx_ack
//   in_tx_ack      one-cycle pulse, controller accepted out_tx_data
//   out_regs       flat register bank, reg i at [8i+7:8i]
//   out_err_count  saturating error counter
//   out_busy       high whenever the sequencer is not idle
// ============================================================================
module ftdi_cmd_sequencer #(
  parameter int         NUM_REGS       = 8,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ACK_BYTE       = 8'hA5,
  parameter logic [7:0] ERR_BYTE       = 8'hEE
) (
  input  logic                  in_clk,
  input  logic                  in_reset_n,
  input  logic [7:0]            in_rx_data,
  input  logic                  in_rx_valid,
  output logic [7:0]            out_tx_data,
  output logic                  out_tx_valid,
  input  logic                  in_tx_ack,
  output logic [NUM_REGS*8-1:0] out_regs,
  output logic [7:0]            out_err_count,
  output logic                  out_busy
);

  localparam int         AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int         TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0] NREG8     = 8'(NUM_REGS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;
  localparam logic [7:0] OP_CLEAR  = 8'h04;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    GET_DATA = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q;
  logic            busy_q;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      err_q;
  logic [7:0]      regs_q [NUM_REGS];

  logic            w_err_inc;
  logic            w_err_clr;
  logic            w_wr_en;

  // --------------------------------------------------------------------------
  // Next-state and command decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    tx_data_d = tx_data_q;
    tmo_d     = '0;
    w_err_inc = 1'b0;
    w_err_clr = 1'b0;
    w_wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_rx_valid) begin
          case (in_rx_data)
            OP_WRITE: begin
              is_wr_d = 1'b1;
              state_d = GET_ADDR;
            end
            OP_READ: begin
              is_wr_d = 1'b0;
              state_d = GET_ADDR;
            end
            OP_STATUS: begin
              // Reports the count as it stood before this byte.
              tx_data_d = err_q;
              state_d   = RESP;
            end
            OP_CLEAR: begin
              w_err_clr = 1'b1;
              tx_data_d = ACK_BYTE;
              state_d   = RESP;
            end
            default: begin
              w_err_inc = 1'b1;
              tx_data_d = ERR_BYTE;
              state_d   = RESP;
            end
          endcase
        end
      end

      GET_ADDR: begin
        if (in_rx_valid) begin
          if (is_wr_q) begin
            addr_d  = in_rx_data;
            state_d = GET_DATA;
          end else if (in_rx_data < NREG8) begin
            tx_data_d = regs_q[in_rx_data[AW-1:0]];
            state_d   = RESP;
          end else begin
            w_err_inc = 1'b1;
            tx_data_d = ERR_BYTE;
            state_d   = RESP;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Host stalled mid-command: drop it silently.
          w_err_inc = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      GET_DATA: begin
        if (in_rx_valid) begin
          if (addr_q < NREG8) begin
            w_wr_en   = 1'b1;
            tx_data_d = ACK_BYTE;
          end else begin
            w_err_inc = 1'b1;
            tx_data_d = ERR_BYTE;
          end
          state_d = RESP;
        end else if (tmo_q == TMO_LAST) begin
          w_err_inc = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      RESP: begin
        // Bytes arriving while a response is pending cannot be queued.
        if (in_rx_valid) begin
          w_err_inc = 1'b1;
        end
        if (in_tx_ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= (state_d == RESP);
      busy_q     <= (state_d != IDLE);
      tmo_q      <= tmo_d;
    end
  end

  // Clear has priority; increments stop at 255.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      err_q <= '0;
    end else if (w_err_clr) begin
      err_q <= '0;
    end else if (w_err_inc && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_wr_en) begin
      regs_q[addr_q[AW-1:0]] <= in_rx_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all straight from flops
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
      assign out_regs[8*gi +: 8] = regs_q[gi];
    end
  endgenerate

  assign out_tx_data   = tx_data_q;
  assign out_tx_valid  = tx_valid_q;
  assign out_err_count = err_q;
  assign out_busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ftdi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ftdi_cmd_sequencer
// Description : Directed self-checking bench for ftdi_cmd_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ftdi_cmd_sequencer;

  localparam int NREGS = 8;
  localparam int TMO   = 16;

  logic             clk;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ack;
  logic [NREGS*8-1:0] regs;
  logic [7:0]       err_count;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  ftdi_cmd_sequencer #(
    .NUM_REGS      (NREGS),
    .TIMEOUT_CYCLES(TMO),
    .ACK_BYTE      (8'hA5),
    .ERR_BYTE      (8'hEE)
  ) dut (
    .in_clk       (clk),
    .in_reset_n   (rst_n),
    .in_rx_data   (rx_data),
    .in_rx_valid  (rx_valid),
    .out_tx_data  (tx_data),
    .out_tx_valid (tx_valid),
    .in_tx_ack    (tx_ack),
    .out_regs     (regs),
    .out_err_count(err_count),
    .out_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] reg_at(input int i);
    return regs[8*i +: 8];
  endfunction

  // Stimulus changes on the falling edge; DUT samples on the rising edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    n_checks++; if (regs !== '0) begin n_fail++; $display("FAIL reset_regs got %h want 0", regs); end
    n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL reset_err got %h want 00", err_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_write();
    send_byte(8'h01); idle(2);
    send_byte(8'h03);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_mid got %b want 1", busy); end
    idle(1);
    send_byte(8'h5A);
    n_checks++; if (reg_at(3) !== 8'h5A) begin n_fail++; $display("FAIL write_reg3 got %h want 5a", reg_at(3)); end
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL write_tx_valid got %b want 1", tx_valid); end
    n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL write_tx_data got %h want a5", tx_data); end
    idle(3);
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL write_tx_held got %b want 1", tx_valid); end
    do_ack();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL write_ack_valid got %b want 0", tx_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_ack_busy got %b want 0", busy); end
  endtask

  task automatic test_read();
    send_byte(8'h02); send_byte(8'h03);
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL read_valid got %b want 1", tx_valid); end
    n_checks++; if (tx_data !== 8'h5A) begin n_fail++; $display("FAIL read_data got %h want 5a", tx_data); end
    do_ack();
    send_byte(8'h02); send_byte(8'h09);
    n_checks++; if (tx_data !== 8'hEE) begin n_fail++; $display("FAIL read_badaddr_data got %h want ee", tx_data); end
    n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL read_badaddr_err got %0d want 1", err_count); end
    do_ack();
  endtask

  task automatic test_status_clear();
    do_reset();
    send_byte(8'h7F);
    n_checks++; if (tx_data !== 8'hEE) begin n_fail++; $display("FAIL bad_op_data got %h want ee", tx_data); end
    n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL bad_op_err got %0d want 1", err_count); end
    do_ack();
    send_byte(8'h03);
    n_checks++; if (tx_data !== 8'h01) begin n_fail++; $display("FAIL status_data got %h want 01", tx_data); end
    do_ack();
    send_byte(8'h04);
    n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL clear_data got %h want a5", tx_data); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL clear_err got %0d want 0", err_count); end
    do_ack();
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h33);
    do_ack();
    send_byte(8'h01); send_byte(8'h05);
    idle(TMO - 1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_before got busy %b want 1", busy); end
    idle(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy got %b want 0", busy); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_tx_valid got %b want 0", tx_valid); end
    n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL tmo_err got %0d want 1", err_count); end
    n_checks++; if (reg_at(5) !== 8'h33) begin n_fail++; $display("FAIL tmo_reg5 got %h want 33", reg_at(5)); end
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h11);
    n_checks++; if (reg_at(5) !== 8'h11) begin n_fail++; $display("FAIL tmo_rewrite got %h want 11", reg_at(5)); end
    do_ack();
  endtask

  task automatic test_overrun();
    do_reset();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'hC3);
    do_ack();
    send_byte(8'h02); send_byte(8'h02);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h10 + 8'(i));
      n_checks++; if (tx_data !== 8'hC3 || tx_valid !== 1'b1) begin
        n_fail++; $display("FAIL overrun_hold%0d got %h/%b want c3/1", i, tx_data, tx_valid);
      end
    end
    @(negedge clk);
    rx_data = 8'h02; rx_valid = 1'b1; tx_ack = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; tx_ack = 1'b0;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_ack_valid got %b want 0", tx_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL overrun_busy got %b want 0", busy); end
    n_checks++; if (err_count !== 8'd4) begin n_fail++; $display("FAIL overrun_err got %0d want 4", err_count); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hFF);
      do_ack();
    end
    n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_err got %0d want 255", err_count); end
    send_byte(8'h03);
    n_checks++; if (tx_data !== 8'hFF) begin n_fail++; $display("FAIL sat_status got %h want ff", tx_data); end
    do_ack();
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h7F); do_ack();
    send_byte(8'h01); send_byte(8'h04);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || err_count !== 8'd0 || tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_getdata got busy %b err %0d valid %b want 0/0/0", busy, err_count, tx_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    send_byte(8'h01); send_byte(8'h04); send_byte(8'h77);
    n_checks++; if (tx_valid !== 1'b1 || reg_at(4) !== 8'h77) begin
      n_fail++; $display("FAIL rst_pre_resp got valid %b reg4 %h want 1/77", tx_valid, reg_at(4));
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || regs !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_resp got valid %b data %h regs %h busy %b want all 0", tx_valid, tx_data, regs, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    send_byte(8'h01); send_byte(8'h06); send_byte(8'h99);
    n_checks++; if (reg_at(6) !== 8'h99 || tx_data !== 8'hA5 || tx_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_after_write got reg6 %h data %h valid %b want 99/a5/1", reg_at(6), tx_data, tx_valid);
    end
    do_ack();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_after_busy got %b want 0", busy); end
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ack   = 1'b0;
    idle(2);
    rst_n = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_status_clear();
    test_timeout();
    test_overrun();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
